// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: two write ports, NRD packed read ports,
// the issue/flush scoreboard controls and the scoreboard status outputs.
interface regfile_sb_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NRD    = 3
);
   logic                     we0;
   logic [ADDR_W-1:0]        waddr0;
   logic [DATA_W-1:0]        wdata0;
   logic                     we1;
   logic [ADDR_W-1:0]        waddr1;
   logic [DATA_W-1:0]        wdata1;
   logic [NRD*ADDR_W-1:0]    raddr;
   logic [NRD*DATA_W-1:0]    rdata;
   logic [NRD-1:0]           rbusy;
   logic                     issue_valid;
   logic [ADDR_W-1:0]        issue_addr;
   logic                     flush;
   logic [ADDR_W:0]          busy_cnt;

   modport master (
      output we0, waddr0, wdata0,
      output we1, waddr1, wdata1,
      output raddr,
      output issue_valid, issue_addr, flush,
      input  rdata, rbusy, busy_cnt
   );

   modport slave (
      input  we0, waddr0, wdata0,
      input  we1, waddr1, wdata1,
      input  raddr,
      input  issue_valid, issue_addr, flush,
      output rdata, rbusy, busy_cnt
   );
endinterface

// File: rtl/regfile_sb.sv
// Register file with two write ports, NRD combinational read ports,
// optional write-to-read forwarding and a per-register busy scoreboard
// with a registered population count of busy entries.
module regfile_sb #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NRD    = 3,
   parameter bit          BYPASS = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   regfile_sb_if.slave   bus
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_nxt;
   logic [ADDR_W:0]   cnt_q;
   logic [ADDR_W:0]   cnt_nxt;
   logic              wr0;
   logic              wr1;
   logic              iss;

   // Register 0 is hardwired, so writes and issues to it are dropped here.
   assign wr0 = bus.we0 && (bus.waddr0 != '0);
   assign wr1 = bus.we1 && (bus.waddr1 != '0);
   assign iss = bus.issue_valid && (bus.issue_addr != '0);

   // Next busy vector: flush clears everything and drops the issue;
   // otherwise writes clear, then an issue sets (set wins on a collision).
   always_comb begin
      busy_nxt = busy;
      if (bus.flush) begin
         busy_nxt = '0;
      end else begin
         if (wr0) busy_nxt[bus.waddr0] = 1'b0;
         if (wr1) busy_nxt[bus.waddr1] = 1'b0;
         if (iss) busy_nxt[bus.issue_addr] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   // Population count of the next busy vector, so busy_cnt lands on the
   // same edge as the bits it counts; bit 0 is never set so it is skipped.
   always_comb begin
      cnt_nxt = '0;
      for (int unsigned j = 1; j < DEPTH; j++) begin
         cnt_nxt = cnt_nxt + (ADDR_W + 1)'(busy_nxt[ADDR_W'(j)]);
      end
   end

   // Array, scoreboard and count update; reset wins over all activity.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned j = 0; j < DEPTH; j++) begin
            regs[ADDR_W'(j)] <= '0;
         end
         busy  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr0) regs[bus.waddr0] <= bus.wdata0;
         // Issued after port 0 so port 1 wins a same-address collision.
         if (wr1) regs[bus.waddr1] <= bus.wdata1;
         busy  <= busy_nxt;
         cnt_q <= cnt_nxt;
      end
   end

   assign bus.busy_cnt = cnt_q;

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              b;

      assign a = bus.raddr[g*ADDR_W +: ADDR_W];

      // Read port: array lookup, forwarded from a live write when enabled
      // (port 1 last so it has priority); forwarding is suppressed while
      // reset is asserted so the port shows the stored contents.
      always_comb begin
         d = regs[a];
         b = busy[a];
         if (BYPASS && rst_n) begin
            if (wr0 && (bus.waddr0 == a)) begin
               d = bus.wdata0;
               b = 1'b0;
            end
            if (wr1 && (bus.waddr1 == a)) begin
               d = bus.wdata1;
               b = 1'b0;
            end
         end
         if (a == '0) begin
            d = '0;
            b = 1'b0;
         end
      end

      assign bus.rdata[g*DATA_W +: DATA_W] = d;
      assign bus.rbusy[g]                  = b;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one instance with forwarding and one
// without, both driven by the same stimulus.
module tb_regfile_sb;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(3)) bus_b ();
   regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(3)) bus_n ();

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(3), .BYPASS(1'b1)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b.slave)
   );

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(3), .BYPASS(1'b0)) dut_n (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_n.slave)
   );

   assign bus_n.we0         = bus_b.we0;
   assign bus_n.waddr0      = bus_b.waddr0;
   assign bus_n.wdata0      = bus_b.wdata0;
   assign bus_n.we1         = bus_b.we1;
   assign bus_n.waddr1      = bus_b.waddr1;
   assign bus_n.wdata1      = bus_b.wdata1;
   assign bus_n.raddr       = bus_b.raddr;
   assign bus_n.issue_valid = bus_b.issue_valid;
   assign bus_n.issue_addr  = bus_b.issue_addr;
   assign bus_n.flush       = bus_b.flush;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] rd_b(input int i);
      return bus_b.rdata[i*32 +: 32];
   endfunction
   function automatic logic [31:0] rd_n(input int i);
      return bus_n.rdata[i*32 +: 32];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus_b.we0 = 1'b0;  bus_b.waddr0 = '0; bus_b.wdata0 = '0;
      bus_b.we1 = 1'b0;  bus_b.waddr1 = '0; bus_b.wdata1 = '0;
      bus_b.issue_valid = 1'b0; bus_b.issue_addr = '0;
      bus_b.flush = 1'b0;
   endtask

   task automatic set_raddr(input int i, input logic [4:0] a);
      bus_b.raddr[i*5 +: 5] = a;
   endtask

   task automatic test_reset();
      idle();
      bus_b.raddr = '0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus_b.busy_cnt !== 6'd0) begin
         failures++;
         $display("FAIL reset_cnt: got %0d expected 0", bus_b.busy_cnt);
      end
      for (int a = 0; a < 32; a++) begin
         set_raddr(0, 5'(a));
         #1;
         checks++;
         if (rd_b(0) !== 32'h0 || rd_n(0) !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata[%0d]: got %h/%h expected 0", a, rd_b(0), rd_n(0));
         end
         checks++;
         if (bus_b.rbusy[0] !== 1'b0 || bus_n.rbusy[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_rbusy[%0d]: got %b/%b expected 0", a, bus_b.rbusy[0], bus_n.rbusy[0]);
         end
      end
   endtask

   task automatic test_bypass();
      idle();
      bus_b.we0 = 1'b1; bus_b.waddr0 = 5'd5; bus_b.wdata0 = 32'hDEADBEEF;
      set_raddr(0, 5'd5);
      #1;
      checks++;
      if (rd_b(0) !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL bypass_fwd: got %h expected deadbeef", rd_b(0));
      end
      checks++;
      if (rd_n(0) !== 32'h0) begin
         failures++;
         $display("FAIL nobypass_same_cycle: got %h expected 0", rd_n(0));
      end
      tick();
      idle();
      #1;
      checks++;
      if (rd_n(0) !== 32'hDEADBEEF || rd_b(0) !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL write_next_cycle: got %h/%h expected deadbeef", rd_b(0), rd_n(0));
      end
   endtask

   task automatic test_write_priority();
      idle();
      bus_b.we0 = 1'b1; bus_b.waddr0 = 5'd7; bus_b.wdata0 = 32'h11;
      bus_b.we1 = 1'b1; bus_b.waddr1 = 5'd7; bus_b.wdata1 = 32'h22;
      set_raddr(0, 5'd7);
      #1;
      checks++;
      if (rd_b(0) !== 32'h22) begin
         failures++;
         $display("FAIL bypass_prio: got %h expected 22", rd_b(0));
      end
      tick();
      idle();
      set_raddr(1, 5'd5);
      set_raddr(2, 5'd7);
      #1;
      checks++;
      if (rd_b(0) !== 32'h22 || rd_n(0) !== 32'h22) begin
         failures++;
         $display("FAIL write_prio: got %h/%h expected 22", rd_b(0), rd_n(0));
      end
      checks++;
      if (rd_b(1) !== 32'hDEADBEEF || rd_n(2) !== 32'h22) begin
         failures++;
         $display("FAIL multi_port: got %h/%h expected deadbeef/22", rd_b(1), rd_n(2));
      end
      bus_b.we0 = 1'b1; bus_b.waddr0 = 5'd0; bus_b.wdata0 = 32'hFFFFFFFF;
      bus_b.we1 = 1'b1; bus_b.waddr1 = 5'd0; bus_b.wdata1 = 32'h1234;
      set_raddr(0, 5'd0);
      #1;
      checks++;
      if (rd_b(0) !== 32'h0) begin
         failures++;
         $display("FAIL r0_bypass: got %h expected 0", rd_b(0));
      end
      tick();
      idle();
      #1;
      checks++;
      if (rd_b(0) !== 32'h0 || rd_n(0) !== 32'h0) begin
         failures++;
         $display("FAIL r0_write: got %h/%h expected 0", rd_b(0), rd_n(0));
      end
   endtask

   task automatic test_busy();
      logic [5:0] exp_cnt [3] = '{6'd1, 6'd2, 6'd2};
      logic [4:0] iss_seq [3] = '{5'd3, 5'd4, 5'd3};
      idle();
      for (int k = 0; k < 3; k++) begin
         bus_b.issue_valid = 1'b1; bus_b.issue_addr = iss_seq[k];
         tick();
         checks++;
         if (bus_b.busy_cnt !== exp_cnt[k]) begin
            failures++;
            $display("FAIL issue_cnt[%0d]: got %0d expected %0d", k, bus_b.busy_cnt, exp_cnt[k]);
         end
      end
      idle();
      set_raddr(0, 5'd3);
      #1;
      checks++;
      if (bus_b.rbusy[0] !== 1'b1 || bus_n.rbusy[0] !== 1'b1) begin
         failures++;
         $display("FAIL rbusy_set: got %b/%b expected 1", bus_b.rbusy[0], bus_n.rbusy[0]);
      end
      bus_b.we0 = 1'b1; bus_b.waddr0 = 5'd3; bus_b.wdata0 = 32'h33;
      #1;
      checks++;
      if (bus_b.rbusy[0] !== 1'b0) begin
         failures++;
         $display("FAIL rbusy_bypass: got %b expected 0", bus_b.rbusy[0]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (bus_b.busy_cnt !== 6'd1) begin
         failures++;
         $display("FAIL write_clear_cnt: got %0d expected 1", bus_b.busy_cnt);
      end
      checks++;
      if (bus_b.rbusy[0] !== 1'b0 || bus_n.rbusy[0] !== 1'b0 || rd_n(0) !== 32'h33) begin
         failures++;
         $display("FAIL write_clear: got %b/%b data %h expected 0/0 data 33", bus_b.rbusy[0], bus_n.rbusy[0], rd_n(0));
      end
      bus_b.issue_valid = 1'b1; bus_b.issue_addr = 5'd4;
      bus_b.we1 = 1'b1; bus_b.waddr1 = 5'd4; bus_b.wdata1 = 32'h44;
      tick();
      idle();
      set_raddr(0, 5'd4);
      #1;
      checks++;
      if (bus_b.busy_cnt !== 6'd1 || bus_n.rbusy[0] !== 1'b1) begin
         failures++;
         $display("FAIL issue_write_same: got cnt %0d rbusy %b expected 1/1", bus_b.busy_cnt, bus_n.rbusy[0]);
      end
      checks++;
      if (rd_n(0) !== 32'h44) begin
         failures++;
         $display("FAIL issue_write_data: got %h expected 44", rd_n(0));
      end
      bus_b.issue_valid = 1'b1; bus_b.issue_addr = 5'd0;
      set_raddr(1, 5'd0);
      tick();
      idle();
      #1;
      checks++;
      if (bus_b.busy_cnt !== 6'd1 || bus_b.rbusy[1] !== 1'b0) begin
         failures++;
         $display("FAIL issue_r0: got cnt %0d rbusy %b expected 1/0", bus_b.busy_cnt, bus_b.rbusy[1]);
      end
   endtask

   task automatic test_flush();
      idle();
      bus_b.we0 = 1'b1; bus_b.waddr0 = 5'd4; bus_b.wdata0 = 32'h4444;
      bus_b.issue_valid = 1'b1; bus_b.issue_addr = 5'd3;
      tick();
      idle();
      bus_b.issue_valid = 1'b1; bus_b.issue_addr = 5'd9;
      tick();
      idle();
      checks++;
      if (bus_b.busy_cnt !== 6'd2) begin
         failures++;
         $display("FAIL pre_flush_cnt: got %0d expected 2", bus_b.busy_cnt);
      end
      bus_b.flush = 1'b1;
      bus_b.issue_valid = 1'b1; bus_b.issue_addr = 5'd12;
      bus_b.we0 = 1'b1; bus_b.waddr0 = 5'd20; bus_b.wdata0 = 32'h2020;
      tick();
      idle();
      set_raddr(0, 5'd12);
      set_raddr(1, 5'd3);
      set_raddr(2, 5'd9);
      #1;
      checks++;
      if (bus_b.busy_cnt !== 6'd0) begin
         failures++;
         $display("FAIL flush_cnt: got %0d expected 0", bus_b.busy_cnt);
      end
      checks++;
      if (bus_b.rbusy !== 3'b000 || bus_n.rbusy !== 3'b000) begin
         failures++;
         $display("FAIL flush_rbusy: got %b/%b expected 000", bus_b.rbusy, bus_n.rbusy);
      end
      set_raddr(0, 5'd20);
      #1;
      checks++;
      if (rd_n(0) !== 32'h2020) begin
         failures++;
         $display("FAIL flush_write: got %h expected 2020", rd_n(0));
      end
   endtask

   task automatic test_reset_mid();
      idle();
      for (int a = 1; a < 32; a++) begin
         bus_b.we0 = 1'b1; bus_b.waddr0 = 5'(a); bus_b.wdata0 = 32'h100 + 32'(a);
         tick();
      end
      idle();
      for (int a = 1; a <= 5; a++) begin
         bus_b.issue_valid = 1'b1; bus_b.issue_addr = 5'(a);
         tick();
      end
      idle();
      set_raddr(0, 5'd17);
      #1;
      checks++;
      if (bus_b.busy_cnt !== 6'd5 || rd_n(0) !== 32'h111) begin
         failures++;
         $display("FAIL pre_reset: got cnt %0d data %h expected 5/111", bus_b.busy_cnt, rd_n(0));
      end
      rst_n = 1'b0;
      bus_b.we0 = 1'b1; bus_b.waddr0 = 5'd6; bus_b.wdata0 = 32'hBAD;
      bus_b.issue_valid = 1'b1; bus_b.issue_addr = 5'd10;
      #1;
      checks++;
      if (rd_b(0) !== 32'h111) begin
         failures++;
         $display("FAIL reset_comb_read: got %h expected 111", rd_b(0));
      end
      tick();
      rst_n = 1'b1;
      idle();
      #1;
      checks++;
      if (bus_b.busy_cnt !== 6'd0 || bus_n.busy_cnt !== 6'd0) begin
         failures++;
         $display("FAIL mid_reset_cnt: got %0d/%0d expected 0", bus_b.busy_cnt, bus_n.busy_cnt);
      end
      for (int a = 0; a < 32; a++) begin
         set_raddr(0, 5'(a));
         #1;
         checks++;
         if (rd_b(0) !== 32'h0 || rd_n(0) !== 32'h0 || bus_b.rbusy[0] !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_reg[%0d]: got %h/%h rbusy %b expected 0", a, rd_b(0), rd_n(0), bus_b.rbusy[0]);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      idle();
      bus_b.raddr = '0;
      test_reset();
      test_bypass();
      test_write_priority();
      test_busy();
      test_flush();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameters, one per line (name, default, meaning):
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NRD, 3, number of read ports
- BYPASS, 1, 1 = write-to-read forwarding enabled, 0 = disabled
REQ-002 SHALL provide ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock, all state updates on rising edge
- rst_n, in, 1, synchronous active-low reset, sampled on rising edge of clk
- we0, in, 1, write port 0 enable
- waddr0, in, ADDR_W, write port 0 address
- wdata0, in, DATA_W, write port 0 data
- we1, in, 1, write port 1 enable
- waddr1, in, ADDR_W, write port 1 address
- wdata1, in, DATA_W, write port 1 data
- raddr, in, NRD*ADDR_W, read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rdata, out, NRD*DATA_W, read data, port i at bits [i*DATA_W +: DATA_W]
- rbusy, out, NRD, per-read-port busy flag (pending producer)
- issue_valid, in, 1, marks issue_addr as having an in-flight producer
- issue_addr, in, ADDR_W, destination register of the issued instruction
- flush, in, 1, clears all busy bits
- busy_cnt, out, ADDR_W+1, number of registers currently busy
REQ-003 Clock and reset SHALL be one clock, clk; reset rst_n is synchronous and active-low.

Function
REQ-004 Register 0 SHALL read as 0, SHALL never be written, and SHALL never be busy.
REQ-005 Writes SHALL take effect on the rising edge when weN=1 and waddrN!=0.
REQ-006 If we0 and we1 target the same non-zero address in one cycle, wdata1 SHALL be stored (port 1 has priority).
REQ-007 Reads SHALL be combinational: rdata[i] = registers[raddr[i]].
REQ-008 With BYPASS=1, a read whose address matches an enabled same-cycle write SHALL return that write's wdata, with port 1 taking priority over port 0.
REQ-009 With BYPASS=0, a same-cycle write SHALL NOT be visible on rdata until the next cycle.
REQ-010 busy[a] SHALL be set on the edge where issue_valid=1 and issue_addr=a!=0.
REQ-011 busy[a] SHALL be cleared on the edge where either write port writes a.
REQ-012 If an issue and a write hit the same address in one cycle, set SHALL win: busy[a]=1 afterwards, while data is still updated.
REQ-013 flush=1 SHALL clear every busy bit on that edge.
REQ-014 flush SHALL override a same-cycle issue, which is dropped.
REQ-015 Writes coincident with flush SHALL still update data.
REQ-016 rbusy[i] SHALL equal busy[raddr[i]] while no write to that address is enabled in the same cycle.
REQ-017 With BYPASS=1, rbusy[i] SHALL be 0 whenever a same-cycle write to that address is enabled.
REQ-018 rbusy[i] SHALL be 0 for address 0.
REQ-019 busy_cnt SHALL be a registered population count of the busy bits, updated on the same edge as the bits themselves (no extra cycle of latency).
REQ-020 busy_cnt SHALL never exceed 2**ADDR_W-1.
REQ-021 Issuing to an address that is already busy SHALL leave busy at 1 and SHALL not double-count in busy_cnt.

Reset
REQ-022 On any rising edge with rst_n=0, every register SHALL be set to 0, every busy bit to 0, and busy_cnt to 0.
REQ-023 During a reset edge, writes, issues and flush SHALL be ignored.
REQ-024 During reset, rdata SHALL reflect the current array contents combinationally; after the reset edge every rdata SHALL read 0 and every rbusy 0.
REQ-025 Reset asserted mid-operation, with busy bits set, SHALL clear all state in one edge.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Reset, then read all 32 addresses -> rdata=0, rbusy=0, busy_cnt=0.
- we0=1, waddr0=5, wdata0=0xDEADBEEF; raddr[0]=5 in the same cycle -> BYPASS=1 gives 0xDEADBEEF; BYPASS=0 gives 0 that cycle and 0xDEADBEEF the next.
- we0 and we1 both to address 7, with 0x11 and 0x22 -> stored value 0x22. Any write to address 0 -> reads back 0.
- Issue addresses 3, 4, 3 on consecutive cycles -> busy_cnt goes 1, 2, 2. A write to 3 -> busy_cnt 1 and rbusy for 3 is 0. In a cycle with issue=4 and write=4 -> busy stays 1 and data updates.
- Busy bits set on 3 and 9, then flush with issue_valid=1 to 12 -> all busy bits 0, busy_cnt=0, register 12 not busy.
- rst_n=0 for one cycle after registers 1..31 are written and 5 are busy -> all registers 0 and busy_cnt=0 on the following cycle.
